// File: rtl/epd_pkg.sv
// Shared types and constants for the Ethernet frame monitor:
// parser states, error codes, framing bytes and the DST filter helper.
package epd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DST      = 3'd2,
        ST_SRC      = 3'd3,
        ST_TYPELEN  = 3'd4,
        ST_PAYLOAD  = 3'd5,
        ST_DROP     = 3'd6
    } epd_state_e;

    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_BAD_PREAMBLE = 3'd1;
    localparam logic [2:0] ERR_BAD_SFD      = 3'd2;
    localparam logic [2:0] ERR_RUNT         = 3'd3;
    localparam logic [2:0] ERR_UNDERSIZE    = 3'd4;
    localparam logic [2:0] ERR_OVERSIZE     = 3'd5;
    localparam logic [2:0] ERR_LEN_MISMATCH = 3'd6;
    localparam logic [2:0] ERR_DST_FILTER   = 3'd7;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [47:0] BROADCAST_ADDR = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] MAX_LEN_FIELD  = 16'd1500;

    // A destination is ours if it is our own address or broadcast.
    function automatic logic dst_accepted(input logic [47:0] dst, input logic [47:0] own);
        return (dst == own) || (dst == BROADCAST_ADDR);
    endfunction

endpackage

// File: rtl/epd_frame_monitor_if.sv
// Byte-stream and result bundle of the frame monitor.
// my_addr only exists when EPD_DST_FILTER_EN is defined.
interface epd_frame_monitor_if #(
    parameter int CNT_W = 4,
    parameter int PL_W  = 11
);
    logic [7:0]       data;
    logic             control;
    logic             clear_counters;
`ifdef EPD_DST_FILTER_EN
    logic [47:0]      my_addr;
`endif
    logic             preamble_valid;
    logic             dst_addr_valid;
    logic             src_addr_valid;
    logic             type_length_valid;
    logic             packet_size_valid;
    logic [CNT_W-1:0] valid_packet_counter;
    logic [CNT_W-1:0] bad_packet_counter;
    logic [47:0]      dst_addr;
    logic [47:0]      src_addr;
    logic [15:0]      type_length;
    logic [PL_W-1:0]  payload_len;
    logic [2:0]       frame_error;
    logic             error_valid;

    modport master (
`ifdef EPD_DST_FILTER_EN
        output my_addr,
`endif
        output data, control, clear_counters,
        input  preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
        input  packet_size_valid, valid_packet_counter, bad_packet_counter,
        input  dst_addr, src_addr, type_length, payload_len, frame_error, error_valid
    );

    modport slave (
`ifdef EPD_DST_FILTER_EN
        input  my_addr,
`endif
        input  data, control, clear_counters,
        output preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
        output packet_size_valid, valid_packet_counter, bad_packet_counter,
        output dst_addr, src_addr, type_length, payload_len, frame_error, error_valid
    );
endinterface

// File: rtl/epd_event_counter.sv
// Wrapping event counter; a clear on the same cycle as an increment wins.
module epd_event_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_r;

    // Count register: clear has priority over increment, wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/epd_frame_monitor.sv
// Passive Ethernet receive-stream monitor: parses header fields, checks payload size and
// the 802.3 length field, and counts good/bad frames. Optional EPD_DST_FILTER_EN adds DST filtering.
module epd_frame_monitor
    import epd_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MAX_PAYLOAD  = 1500
) (
    input logic               clock,
    input logic               reset,
    epd_frame_monitor_if.slave bus
);
    localparam int PL_W    = $clog2(MAX_PAYLOAD + 2);
    localparam int IDX_MAX = (PREAMBLE_LEN > 5) ? PREAMBLE_LEN : 5;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);
    localparam int CMP_W   = (PL_W > 16) ? PL_W : 16;
    localparam logic [IDX_W-1:0] PRE_LEN_C   = IDX_W'(PREAMBLE_LEN);
    localparam logic [IDX_W-1:0] LAST_ADDR_C = IDX_W'(5);
    localparam logic [IDX_W-1:0] LAST_TL_C   = IDX_W'(1);
    localparam logic [PL_W-1:0]  MIN_PL_C    = PL_W'(MIN_PAYLOAD);
    localparam logic [PL_W-1:0]  MAX_PL_C    = PL_W'(MAX_PAYLOAD);
    localparam logic [PL_W-1:0]  SAT_PL_C    = PL_W'(MAX_PAYLOAD + 1);
    localparam logic [CMP_W-1:0] MIN_CMP_C   = CMP_W'(MIN_PAYLOAD);

    epd_state_e       state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [39:0]      shift_r, shift_s;
    logic [47:0]      shift_in_s;
    logic [PL_W-1:0]  pl_cnt_r, pl_cnt_s;
    logic             pre_v_r, pre_v_s, dst_v_r, dst_v_s, src_v_r, src_v_s;
    logic             tl_v_r, tl_v_s, psv_r, psv_s, err_v_r, err_v_s;
    logic [2:0]       frame_error_r, frame_error_s;
    logic [47:0]      dst_addr_r, dst_addr_s, src_addr_r, src_addr_s;
    logic [15:0]      type_length_r, type_length_s;
    logic [PL_W-1:0]  payload_len_r, payload_len_s;
    logic [CMP_W-1:0] cnt_ext_s, want_len_s;

    // Address/type bytes are assembled here and only published when a field completes.
    assign shift_in_s = {shift_r, bus.data};
    assign cnt_ext_s  = CMP_W'(pl_cnt_r);
    assign want_len_s = (CMP_W'(type_length_r) < MIN_CMP_C) ? MIN_CMP_C : CMP_W'(type_length_r);

    // Next-state, field capture and classification of the byte sampled this cycle.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        shift_s       = shift_r;
        pl_cnt_s      = pl_cnt_r;
        pre_v_s       = 1'b0;
        dst_v_s       = 1'b0;
        src_v_s       = 1'b0;
        tl_v_s        = 1'b0;
        psv_s         = 1'b0;
        err_v_s       = 1'b0;
        frame_error_s = frame_error_r;
        dst_addr_s    = dst_addr_r;
        src_addr_s    = src_addr_r;
        type_length_s = type_length_r;
        payload_len_s = payload_len_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.control) begin
                    if (bus.data == PREAMBLE_BYTE) begin
                        state_s = ST_PREAMBLE;
                        idx_s   = IDX_W'(1);
                    end else begin
                        state_s = ST_DROP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (!bus.control) begin
                    state_s = ST_IDLE; err_v_s = 1'b1; frame_error_s = ERR_RUNT;
                end else if ((bus.data == PREAMBLE_BYTE) && (idx_r < PRE_LEN_C)) begin
                    idx_s = idx_r + IDX_W'(1);
                end else if ((bus.data == SFD_BYTE) && (idx_r == PRE_LEN_C)) begin
                    pre_v_s = 1'b1; state_s = ST_DST; idx_s = '0;
                end else if (bus.data == SFD_BYTE) begin
                    state_s = ST_DROP; err_v_s = 1'b1; frame_error_s = ERR_BAD_SFD;
                end else begin
                    state_s = ST_DROP; err_v_s = 1'b1; frame_error_s = ERR_BAD_PREAMBLE;
                end
            end
            ST_DST: begin
                if (!bus.control) begin
                    state_s = ST_IDLE; err_v_s = 1'b1; frame_error_s = ERR_RUNT;
                end else begin
                    shift_s = shift_in_s[39:0];
                    if (idx_r == LAST_ADDR_C) begin
`ifdef EPD_DST_FILTER_EN
                        if (!dst_accepted(shift_in_s, bus.my_addr)) begin
                            state_s = ST_DROP; err_v_s = 1'b1; frame_error_s = ERR_DST_FILTER;
                        end else begin
                            dst_addr_s = shift_in_s; dst_v_s = 1'b1; state_s = ST_SRC; idx_s = '0;
                        end
`else
                        dst_addr_s = shift_in_s; dst_v_s = 1'b1; state_s = ST_SRC; idx_s = '0;
`endif
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end
            end
            ST_SRC: begin
                if (!bus.control) begin
                    state_s = ST_IDLE; err_v_s = 1'b1; frame_error_s = ERR_RUNT;
                end else begin
                    shift_s = shift_in_s[39:0];
                    if (idx_r == LAST_ADDR_C) begin
                        src_addr_s = shift_in_s; src_v_s = 1'b1; state_s = ST_TYPELEN; idx_s = '0;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end
            end
            ST_TYPELEN: begin
                if (!bus.control) begin
                    state_s = ST_IDLE; err_v_s = 1'b1; frame_error_s = ERR_RUNT;
                end else begin
                    shift_s = shift_in_s[39:0];
                    if (idx_r == LAST_TL_C) begin
                        type_length_s = shift_in_s[15:0]; tl_v_s = 1'b1;
                        state_s = ST_PAYLOAD; pl_cnt_s = '0;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bus.control) begin
                    if (pl_cnt_r != SAT_PL_C) begin
                        pl_cnt_s = pl_cnt_r + PL_W'(1);
                    end else begin
                        pl_cnt_s = pl_cnt_r;
                    end
                end else begin
                    payload_len_s = pl_cnt_r;
                    state_s       = ST_IDLE;
                    if (pl_cnt_r < MIN_PL_C) begin
                        err_v_s = 1'b1; frame_error_s = ERR_UNDERSIZE;
                    end else if (pl_cnt_r > MAX_PL_C) begin
                        err_v_s = 1'b1; frame_error_s = ERR_OVERSIZE;
                    end else if ((type_length_r <= MAX_LEN_FIELD) && (cnt_ext_s != want_len_s)) begin
                        err_v_s = 1'b1; frame_error_s = ERR_LEN_MISMATCH;
                    end else begin
                        psv_s = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!bus.control) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Parser state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            idx_r         <= '0;
            shift_r       <= '0;
            pl_cnt_r      <= '0;
            pre_v_r       <= 1'b0;
            dst_v_r       <= 1'b0;
            src_v_r       <= 1'b0;
            tl_v_r        <= 1'b0;
            psv_r         <= 1'b0;
            err_v_r       <= 1'b0;
            frame_error_r <= ERR_NONE;
            dst_addr_r    <= '0;
            src_addr_r    <= '0;
            type_length_r <= '0;
            payload_len_r <= '0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            shift_r       <= shift_s;
            pl_cnt_r      <= pl_cnt_s;
            pre_v_r       <= pre_v_s;
            dst_v_r       <= dst_v_s;
            src_v_r       <= src_v_s;
            tl_v_r        <= tl_v_s;
            psv_r         <= psv_s;
            err_v_r       <= err_v_s;
            frame_error_r <= frame_error_s;
            dst_addr_r    <= dst_addr_s;
            src_addr_r    <= src_addr_s;
            type_length_r <= type_length_s;
            payload_len_r <= payload_len_s;
        end
    end

    epd_event_counter #(.WIDTH(CNT_W)) u_good_cnt (
        .clock (clock), .reset (reset), .clr (bus.clear_counters),
        .inc   (psv_s), .count (bus.valid_packet_counter)
    );

    epd_event_counter #(.WIDTH(CNT_W)) u_bad_cnt (
        .clock (clock), .reset (reset), .clr (bus.clear_counters),
        .inc   (err_v_s), .count (bus.bad_packet_counter)
    );

    assign bus.preamble_valid    = pre_v_r;
    assign bus.dst_addr_valid    = dst_v_r;
    assign bus.src_addr_valid    = src_v_r;
    assign bus.type_length_valid = tl_v_r;
    assign bus.packet_size_valid = psv_r;
    assign bus.error_valid       = err_v_r;
    assign bus.frame_error       = frame_error_r;
    assign bus.dst_addr          = dst_addr_r;
    assign bus.src_addr          = src_addr_r;
    assign bus.type_length       = type_length_r;
    assign bus.payload_len       = payload_len_r;
endmodule
